// File: rtl/dda_traverse_ctrl.sv
// rtl/dda_traverse_ctrl.sv - per-ray register file and query/step sequencing for the 3D DDA voxel walk
// The combinational axis-choose/step datapath lives in the parent; this block holds state and handshakes.
module dda_traverse_ctrl #(
  parameter int W          = 32,
  parameter int STEP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [5:0]            ix0,
  input  logic [5:0]            iy0,
  input  logic [5:0]            iz0,
  input  logic                  sx0,
  input  logic                  sy0,
  input  logic                  sz0,
  input  logic [W-1:0]          next_x0,
  input  logic [W-1:0]          next_y0,
  input  logic [W-1:0]          next_z0,
  input  logic [W-1:0]          inc_x0,
  input  logic [W-1:0]          inc_y0,
  input  logic [W-1:0]          inc_z0,
  input  logic [STEP_CNT_W-1:0] max_steps,
  input  logic                  abort,
  output logic [5:0]            cur_ix,
  output logic [5:0]            cur_iy,
  output logic [5:0]            cur_iz,
  output logic                  cur_sx,
  output logic                  cur_sy,
  output logic                  cur_sz,
  output logic [W-1:0]          cur_next_x,
  output logic [W-1:0]          cur_next_y,
  output logic [W-1:0]          cur_next_z,
  output logic [W-1:0]          cur_inc_x,
  output logic [W-1:0]          cur_inc_y,
  output logic [W-1:0]          cur_inc_z,
  input  logic [5:0]            upd_ix,
  input  logic [5:0]            upd_iy,
  input  logic [5:0]            upd_iz,
  input  logic [W-1:0]          upd_next_x,
  input  logic [W-1:0]          upd_next_y,
  input  logic [W-1:0]          upd_next_z,
  input  logic [1:0]            upd_primary_sel,
  input  logic [2:0]            upd_face_id,
  output logic                  vox_req,
  output logic [4:0]            vox_x,
  output logic [4:0]            vox_y,
  output logic [4:0]            vox_z,
  input  logic                  vox_ack,
  input  logic                  vox_solid,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_hit,
  output logic                  res_oob,
  output logic                  res_timeout,
  output logic [5:0]            res_ix,
  output logic [5:0]            res_iy,
  output logic [5:0]            res_iz,
  output logic [2:0]            res_face,
  output logic [W-1:0]          res_t,
  output logic [STEP_CNT_W-1:0] res_steps
);

  typedef enum logic [1:0] {IDLE, QUERY, STEP, DONE} state_e;

  localparam logic [2:0] NO_FACE = 3'd7;

  state_e                state_q, state_d;
  logic [2:0][5:0]       idx_q, idx_d;
  logic [2:0]            sgn_q, sgn_d;
  logic [2:0][W-1:0]     tmr_q, tmr_d;
  logic [2:0][W-1:0]     inc_q, inc_d;
  logic [STEP_CNT_W-1:0] max_q, max_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]          t_q, t_d;
  logic [2:0]            face_q, face_d;
  logic                  hit_q, hit_d;
  logic                  oob_q, oob_d;
  logic                  to_q, to_d;
  logic                  out_of_bounds;

  // Bit 5 catches both index 32 and the 63 produced by stepping below 0.
  assign out_of_bounds = idx_q[0][5] | idx_q[1][5] | idx_q[2][5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sgn_q   <= '0;
      tmr_q   <= '0;
      inc_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      t_q     <= '0;
      face_q  <= NO_FACE;
      hit_q   <= 1'b0;
      oob_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sgn_q   <= sgn_d;
      tmr_q   <= tmr_d;
      inc_q   <= inc_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      face_q  <= face_d;
      hit_q   <= hit_d;
      oob_q   <= oob_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sgn_d   = sgn_q;
    tmr_d   = tmr_q;
    inc_d   = inc_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    face_d  = face_q;
    hit_d   = hit_q;
    oob_d   = oob_q;
    to_d    = to_q;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            idx_d   = {iz0, iy0, ix0};
            sgn_d   = {sz0, sy0, sx0};
            tmr_d   = {next_z0, next_y0, next_x0};
            inc_d   = {inc_z0, inc_y0, inc_x0};
            max_d   = max_steps;
            cnt_d   = '0;
            t_d     = '0;
            face_d  = NO_FACE;
            hit_d   = 1'b0;
            oob_d   = 1'b0;
            to_d    = 1'b0;
            state_d = QUERY;
          end
        end
        QUERY: begin
          if (out_of_bounds) begin
            oob_d   = 1'b1;
            state_d = DONE;
          end else if (vox_ack) begin
            if (vox_solid) begin
              hit_d   = 1'b1;
              state_d = DONE;
            end else if (cnt_q == max_q) begin
              to_d    = 1'b1;
              state_d = DONE;
            end else begin
              state_d = STEP;
            end
          end
        end
        STEP: begin
          idx_d = {upd_iz, upd_iy, upd_ix};
          tmr_d = {upd_next_z, upd_next_y, upd_next_x};
          case (upd_primary_sel)
            2'd0:    t_d = tmr_q[0];
            2'd1:    t_d = tmr_q[1];
            2'd2:    t_d = tmr_q[2];
            default: t_d = '0;
          endcase
          face_d  = upd_face_id;
          cnt_d   = cnt_q + STEP_CNT_W'(1);
          state_d = QUERY;
        end
        DONE: begin
          if (res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign vox_req     = (state_q == QUERY) && !out_of_bounds;
  assign res_valid   = (state_q == DONE);

  assign cur_ix     = idx_q[0];
  assign cur_iy     = idx_q[1];
  assign cur_iz     = idx_q[2];
  assign cur_sx     = sgn_q[0];
  assign cur_sy     = sgn_q[1];
  assign cur_sz     = sgn_q[2];
  assign cur_next_x = tmr_q[0];
  assign cur_next_y = tmr_q[1];
  assign cur_next_z = tmr_q[2];
  assign cur_inc_x  = inc_q[0];
  assign cur_inc_y  = inc_q[1];
  assign cur_inc_z  = inc_q[2];

  assign vox_x = idx_q[0][4:0];
  assign vox_y = idx_q[1][4:0];
  assign vox_z = idx_q[2][4:0];

  // Indices never move in DONE, so the live registers double as the frozen result.
  assign res_hit     = hit_q;
  assign res_oob     = oob_q;
  assign res_timeout = to_q;
  assign res_ix      = idx_q[0];
  assign res_iy      = idx_q[1];
  assign res_iz      = idx_q[2];
  assign res_face    = face_q;
  assign res_t       = t_q;
  assign res_steps   = cnt_q;

endmodule

// File: tb/tb_dda_traverse_ctrl.sv
// tb/tb_dda_traverse_ctrl.sv - randomized walk checked against a loop-level DDA reference model
module tb_dda_traverse_ctrl;
  localparam int W  = 32;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start_valid, start_ready, abort;
  logic [5:0]    ix0, iy0, iz0;
  logic          sx0, sy0, sz0;
  logic [W-1:0]  next_x0, next_y0, next_z0, inc_x0, inc_y0, inc_z0;
  logic [SW-1:0] max_steps;
  logic [5:0]    cur_ix, cur_iy, cur_iz;
  logic          cur_sx, cur_sy, cur_sz;
  logic [W-1:0]  cur_next_x, cur_next_y, cur_next_z, cur_inc_x, cur_inc_y, cur_inc_z;
  logic [5:0]    upd_ix, upd_iy, upd_iz;
  logic [W-1:0]  upd_next_x, upd_next_y, upd_next_z;
  logic [1:0]    upd_primary_sel;
  logic [2:0]    upd_face_id;
  logic          vox_req, vox_ack, vox_solid;
  logic [4:0]    vox_x, vox_y, vox_z;
  logic          res_valid, res_ready, res_hit, res_oob, res_timeout;
  logic [5:0]    res_ix, res_iy, res_iz;
  logic [2:0]    res_face;
  logic [W-1:0]  res_t;
  logic [SW-1:0] res_steps;

  dda_traverse_ctrl #(.W(W), .STEP_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .ix0(ix0), .iy0(iy0), .iz0(iz0), .sx0(sx0), .sy0(sy0), .sz0(sz0),
    .next_x0(next_x0), .next_y0(next_y0), .next_z0(next_z0),
    .inc_x0(inc_x0), .inc_y0(inc_y0), .inc_z0(inc_z0),
    .max_steps(max_steps), .abort(abort),
    .cur_ix(cur_ix), .cur_iy(cur_iy), .cur_iz(cur_iz),
    .cur_sx(cur_sx), .cur_sy(cur_sy), .cur_sz(cur_sz),
    .cur_next_x(cur_next_x), .cur_next_y(cur_next_y), .cur_next_z(cur_next_z),
    .cur_inc_x(cur_inc_x), .cur_inc_y(cur_inc_y), .cur_inc_z(cur_inc_z),
    .upd_ix(upd_ix), .upd_iy(upd_iy), .upd_iz(upd_iz),
    .upd_next_x(upd_next_x), .upd_next_y(upd_next_y), .upd_next_z(upd_next_z),
    .upd_primary_sel(upd_primary_sel), .upd_face_id(upd_face_id),
    .vox_req(vox_req), .vox_x(vox_x), .vox_y(vox_y), .vox_z(vox_z),
    .vox_ack(vox_ack), .vox_solid(vox_solid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hit(res_hit), .res_oob(res_oob), .res_timeout(res_timeout),
    .res_ix(res_ix), .res_iy(res_iy), .res_iz(res_iz),
    .res_face(res_face), .res_t(res_t), .res_steps(res_steps)
  );

  // Parent step datapath: smallest timer wins, ties go to the lower axis; face = 2*axis + (sign ? 0 : 1).
  logic [1:0] dp_a;
  always_comb begin
    dp_a = (cur_next_y < cur_next_x) ? 2'd1 : 2'd0;
    if (cur_next_z < ((dp_a == 2'd1) ? cur_next_y : cur_next_x)) dp_a = 2'd2;
    upd_ix = cur_ix;  upd_iy = cur_iy;  upd_iz = cur_iz;
    upd_next_x = cur_next_x;  upd_next_y = cur_next_y;  upd_next_z = cur_next_z;
    upd_face_id = 3'd0;
    case (dp_a)
      2'd0: begin
        upd_ix = cur_sx ? cur_ix + 6'd1 : cur_ix - 6'd1;
        upd_next_x = cur_next_x + cur_inc_x;  upd_face_id = {2'd0, ~cur_sx};
      end
      2'd1: begin
        upd_iy = cur_sy ? cur_iy + 6'd1 : cur_iy - 6'd1;
        upd_next_y = cur_next_y + cur_inc_y;  upd_face_id = {2'd1, ~cur_sy};
      end
      default: begin
        upd_iz = cur_sz ? cur_iz + 6'd1 : cur_iz - 6'd1;
        upd_next_z = cur_next_z + cur_inc_z;  upd_face_id = {2'd2, ~cur_sz};
      end
    endcase
    upd_primary_sel = dp_a;
  end

  logic [63:0] dut_res;
  assign dut_res = {res_hit, res_oob, res_timeout, res_ix, res_iy, res_iz, res_face, res_t, res_steps};

  int n_checks = 0;
  int n_fail = 0;
  int ack_cnt = 0;
  int ack_max = 0;
  bit expect_active = 1'b0;

  int          r_idx[3];
  bit          r_sgn[3];
  logic [31:0] r_tm[3];
  logic [31:0] r_inc[3];
  int          r_max;
  bit          grid [0:32767];
  logic [14:0] exp_q[$];
  logic [63:0] m_res;
  int          m_queries;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input bit h, input bit o, input bit t_o, input int x, input int y,
                                       input int z, input int f, input logic [31:0] t, input int s);
    return {h, o, t_o, 6'(x), 6'(y), 6'(z), 3'(f), t, 8'(s)};
  endfunction

  task automatic clear_grid();
    for (int i = 0; i < 32768; i++) grid[i] = 1'b0;
  endtask

  // Walk the ray voxel by voxel the way the algorithm is defined, recording every expected query.
  task automatic run_model();
    int idx[3];
    logic [31:0] tm[3];
    logic [31:0] t;
    int steps, face, a;
    bit h, o, to;
    h = 0; o = 0; to = 0; steps = 0; face = 7; t = '0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin idx[k] = r_idx[k]; tm[k] = r_tm[k]; end
    forever begin
      if (idx[0] >= 32 || idx[1] >= 32 || idx[2] >= 32) begin o = 1; break; end
      exp_q.push_back({idx[0][4:0], idx[1][4:0], idx[2][4:0]});
      if (grid[idx[0] * 1024 + idx[1] * 32 + idx[2]]) begin h = 1; break; end
      if (steps == r_max) begin to = 1; break; end
      a = 0;
      if (tm[1] < tm[a]) a = 1;
      if (tm[2] < tm[a]) a = 2;
      t = tm[a];
      tm[a] = tm[a] + r_inc[a];
      idx[a] = (idx[a] + (r_sgn[a] ? 1 : -1)) & 63;
      face = a * 2 + (r_sgn[a] ? 0 : 1);
      steps++;
    end
    m_res = pack(h, o, to, idx[0], idx[1], idx[2], face, t, steps);
    m_queries = exp_q.size();
  endtask

  task automatic rand_ray();
    int n;
    for (int k = 0; k < 3; k++) begin
      r_idx[k] = $urandom_range(0, 31);
      r_sgn[k] = 1'($urandom_range(0, 1));
      r_tm[k]  = 32'($urandom_range(0, 'hFFF));
      r_inc[k] = 32'($urandom_range(1, 'h400));
    end
    r_max = $urandom_range(0, 40);
    clear_grid();
    n = $urandom_range(0, 3000);
    for (int i = 0; i < n; i++) grid[$urandom_range(0, 32767)] = 1'b1;
  endtask

  task automatic launch();
    int k;
    k = 0;
    @(negedge clk);
    while (!start_ready && k < 100) begin @(negedge clk); k++; end
    check("launch_ready", start_ready, 1);
    start_valid = 1'b1;
    ix0 = 6'(r_idx[0]);  iy0 = 6'(r_idx[1]);  iz0 = 6'(r_idx[2]);
    sx0 = r_sgn[0];      sy0 = r_sgn[1];      sz0 = r_sgn[2];
    next_x0 = r_tm[0];   next_y0 = r_tm[1];   next_z0 = r_tm[2];
    inc_x0 = r_inc[0];   inc_y0 = r_inc[1];   inc_z0 = r_inc[2];
    max_steps = SW'(r_max);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic run_ray(input int hold);
    int k;
    run_model();
    ack_cnt = 0;
    expect_active = 1'b1;
    launch();
    k = 0;
    while (!res_valid && k < 3000) begin @(negedge clk); k++; end
    check("result_arrives", res_valid, 1);
    if (res_valid) begin
      repeat (hold) @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end else begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    expect_active = 1'b0;
  endtask

  // Occupancy responder: ack after 0..ack_max cycles, vox_solid is noise whenever ack is low.
  initial begin
    int dly;
    dly = 0;
    vox_ack = 1'b0;
    vox_solid = 1'b0;
    forever begin
      @(negedge clk);
      vox_ack = 1'b0;
      vox_solid = 1'($urandom_range(0, 1));
      if (vox_req) begin
        if (dly == 0) begin
          vox_ack = 1'b1;
          vox_solid = grid[{vox_x, vox_y, vox_z}];
          dly = $urandom_range(0, ack_max);
        end else begin
          dly--;
        end
      end
    end
  end

  initial begin
    logic [63:0] prev_res;
    bit prev_valid, prev_hs;
    prev_res = '0; prev_valid = 0; prev_hs = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_valid = 0;
        prev_hs = 0;
      end else begin
        check("ready_valid_excl", start_ready & res_valid, 0);
        if (vox_req) check("req_in_bounds", {cur_ix[5], cur_iy[5], cur_iz[5]}, 0);
        if (vox_req && vox_ack) begin
          ack_cnt++;
          if (expect_active) begin
            check("query_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("query_addr", {vox_x, vox_y, vox_z}, exp_q.pop_front());
          end
        end
        if (prev_valid && !prev_hs && res_valid) check("res_stable", dut_res, prev_res);
        if (prev_hs) begin
          check("valid_drop", res_valid, 0);
          check("start_ready_back", start_ready, 1);
        end
        if (expect_active && res_valid && res_ready) begin
          check("result", dut_res, m_res);
          check("queries_left", exp_q.size(), 0);
        end
        prev_valid = res_valid;
        prev_hs = res_valid && res_ready;
        prev_res = dut_res;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; start_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    ix0 = '0; iy0 = '0; iz0 = '0; sx0 = 0; sy0 = 0; sz0 = 0;
    next_x0 = '0; next_y0 = '0; next_z0 = '0; inc_x0 = '0; inc_y0 = '0; inc_z0 = '0;
    max_steps = '0;
    clear_grid();
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", {start_ready, vox_req, res_valid}, 3'b100);
    check("reset_res", dut_res, pack(0, 0, 0, 0, 0, 0, 7, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    // Hit travelling +X
    r_idx = '{5, 5, 5}; r_sgn = '{1, 1, 1};
    r_tm = '{32'h80, 32'hFFFF0000, 32'hFFFF0000}; r_inc = '{32'h100, 32'h100, 32'h100};
    r_max = 20;
    clear_grid(); grid[8 * 1024 + 5 * 32 + 5] = 1'b1;
    run_model();
    check("model_hit_x", m_res, pack(1, 0, 0, 8, 5, 5, 0, 32'h280, 3));
    run_ray(0);

    // Leaving through -X wraps the index to 63
    r_idx = '{1, 0, 0}; r_sgn = '{0, 1, 1};
    r_tm = '{32'h10, 32'hFFFF0000, 32'hFFFF0000}; r_inc = '{32'h10, 32'h100, 32'h100};
    r_max = 20;
    clear_grid();
    run_model();
    check("model_oob_negx", m_res, pack(0, 1, 0, 63, 0, 0, 1, 32'h20, 2));
    check("model_oob_queries", m_queries, 2);
    run_ray(2);

    // Step budget exhaustion
    r_idx = '{3, 4, 5}; r_sgn = '{1, 1, 1};
    r_tm = '{32'd1, 32'd2, 32'd3}; r_inc = '{32'd3, 32'd3, 32'd3};
    r_max = 4;
    run_model();
    check("model_timeout", m_res, pack(0, 0, 1, 5, 5, 6, 0, 32'd4, 4));
    run_ray(1);
    check("timeout_acks", ack_cnt, 5);

    // Hit in the start voxel
    r_idx = '{10, 10, 10}; r_sgn = '{0, 1, 0};
    r_tm = '{32'h33, 32'h22, 32'h11}; r_inc = '{32'h40, 32'h40, 32'h40};
    r_max = 9;
    grid[10 * 1024 + 10 * 32 + 10] = 1'b1;
    run_model();
    check("model_start_hit", m_res, pack(1, 0, 0, 10, 10, 10, 7, 0, 0));
    run_ray(0);

    // Zero budget: a single query then timeout
    r_idx = '{7, 8, 9}; r_max = 0;
    clear_grid();
    run_model();
    check("model_zero_budget", m_res, pack(0, 0, 1, 7, 8, 9, 7, 0, 0));
    run_ray(0);
    check("zero_budget_acks", ack_cnt, 1);

    // Randomized rays with delayed acks and back-pressured results
    ack_max = 3;
    for (int i = 0; i < 40; i++) begin
      rand_ray();
      run_ray((i % 4 == 0) ? 5 : $urandom_range(0, 3));
    end

    // Abort while in STEP
    ack_max = 0;
    r_idx = '{16, 16, 16}; r_sgn = '{1, 0, 1};
    r_tm = '{32'h5, 32'h6, 32'h7}; r_inc = '{32'h10, 32'h10, 32'h10};
    r_max = 20;
    clear_grid();
    launch();
    k = 0;
    #1;
    while (!(vox_req && vox_ack) && k < 20) begin @(negedge clk); #1; k++; end
    check("abort_reach_step", vox_req && vox_ack, 1);
    @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_in_step", {vox_req, res_valid, start_ready}, 3'b000);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_to_idle", {start_ready, res_valid, vox_req}, 3'b100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("abort_no_result", res_valid, 0);
    end

    // Asynchronous reset in the middle of a query
    ack_max = 3;
    rand_ray();
    r_idx = '{20, 21, 22};
    launch();
    #3;
    check("rst_in_query", vox_req, 1);
    rst = 1'b1;
    #1;
    check("rst_ctrl", {start_ready, vox_req, res_valid}, 3'b100);
    check("rst_res", dut_res, pack(0, 0, 0, 0, 0, 0, 7, 0, 0));
    check("rst_idx", {cur_ix, cur_iy, cur_iz, cur_sx, cur_sy, cur_sz}, 0);
    check("rst_tmr", {cur_next_x, cur_next_y, cur_next_z}, 0);
    check("rst_inc", {cur_inc_x, cur_inc_y, cur_inc_z}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      rand_ray();
      run_ray($urandom_range(0, 5));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dda_traverse_ctrl.md
Name: dda_traverse_ctrl

Overview:
Sequential controller for the 3D DDA voxel walk. It holds the per-ray traversal registers (voxel indices, step signs, axis timers, increments) and presents them to the combinational axis-choose and step-update datapath instantiated alongside it in the parent. It registers the updated values that datapath returns, queries voxel occupancy through a handshake, and terminates the ray on hit, out-of-bounds or step budget. It emits one result per accepted ray.

Parameters:
W, 32, timer/increment bit width (matches the step datapath).
STEP_CNT_W, 8, width of the step counter and the max_steps input.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
start_valid  in  1  ray launch request.
start_ready  out  1  high only in IDLE.
ix0, iy0, iz0  in  6 each  start voxel.
sx0, sy0, sz0  in  1 each  step signs (1 = +1).
next_x0, next_y0, next_z0  in  W each  initial axis timers.
inc_x0, inc_y0, inc_z0  in  W each  timer increments.
max_steps  in  STEP_CNT_W  step budget, sampled at launch.
abort  in  1  synchronous abort.
cur_ix, cur_iy, cur_iz  out  6 each  registered indices to the step datapath.
cur_sx, cur_sy, cur_sz  out  1 each  registered signs.
cur_next_x, cur_next_y, cur_next_z  out  W each  registered timers.
cur_inc_x, cur_inc_y, cur_inc_z  out  W each  registered increments.
upd_ix, upd_iy, upd_iz  in  6 each  datapath next indices.
upd_next_x, upd_next_y, upd_next_z  in  W each  datapath next timers.
upd_primary_sel  in  2  primary axis (0=X, 1=Y, 2=Z).
upd_face_id  in  3  primary face id from the datapath.
vox_req  out  1  occupancy query valid.
vox_x, vox_y, vox_z  out  5 each  query address = cur index [4:0].
vox_ack  in  1  query response valid.
vox_solid  in  1  voxel occupied; qualified by vox_ack.
res_valid  out  1  result valid.
res_ready  in  1  result accepted.
res_hit, res_oob, res_timeout  out  1 each  exactly one set when res_valid.
res_ix, res_iy, res_iz  out  6 each  terminating voxel.
res_face  out  3  face entered on the last step; 7 = hit in start voxel.
res_t  out  W  primary-axis timer before the last step; 0 if no step taken.
res_steps  out  STEP_CNT_W  steps taken.

Behaviour:
- Reset:
  - State is IDLE.
  - All registers and outputs are 0, except res_face, which is 7.
  - start_ready is 1. vox_req and res_valid are 0.
- FSM states: IDLE, QUERY, STEP, DONE.
- IDLE, on start_valid:
  - Load all cur_* registers from the *0 inputs.
  - Load max_steps. Clear step_cnt, res_t and last_face (set last_face = 7).
  - Go to QUERY.
- QUERY, out-of-bounds check first:
  - OOB if cur_ix[5], cur_iy[5] or cur_iz[5] is set. This covers both 32 and the 63 wrap from 0-1.
  - On OOB, go to DONE with oob=1. vox_req stays 0 in that cycle.
- QUERY, otherwise:
  - vox_req = 1, as a combinational decode of state, until a cycle with vox_ack=1.
  - vox_ack may arrive in the same cycle as vox_req; minimum QUERY duration is 1 cycle.
  - On ack with solid: go to DONE with hit=1.
  - On ack, not solid, step_cnt == max_steps: go to DONE with timeout=1.
  - On ack, not solid, budget remaining: go to STEP.
- STEP, one cycle:
  - cur_* indices and timers load the upd_* values.
  - res_t loads the cur timer selected by upd_primary_sel, before update. Selector 3 yields 0.
  - last_face loads upd_face_id.
  - step_cnt increments.
  - Go to QUERY.
  - Steady state is 2 cycles per voxel with a zero-wait ack.
- DONE:
  - res_valid = 1. Result fields are frozen and come from the registers on the DONE entry.
  - Fields hold stable until res_valid && res_ready, then go to IDLE.
  - res_valid drops the cycle after the handshake.
  - start_ready returns in IDLE only, so there is no launch in the same cycle as acceptance.
- Increments and signs are constant per ray.
- Timer arithmetic is owned by the datapath; no saturation is added here.
- max_steps = 0: the start voxel is queried once; if empty the result is timeout with res_steps = 0.
- abort:
  - In QUERY, STEP or DONE, go to IDLE next cycle with no result and res_valid low.
  - An outstanding vox_ack after abort is ignored.
  - abort in IDLE is a no-op; abort has priority over every other transition.
- Asynchronous reset mid-ray returns immediately to reset values.

Test Plan:
- Hit in +X: start (5,5,5); sx=sy=sz=1; next_x=0x80, inc_x=0x100; next_y=next_z=0xFFFF0000; solid only at (8,5,5); max_steps=20 -> res_hit=1, res_ix=8, res_steps=3, res_face=0, res_t=0x280.
- -X exit: start (1,0,0), sx=0, X-dominant timers, empty grid -> res_oob=1, res_ix=63, res_steps=2, res_face=1; no vox_req with ix=63.
- Timeout: empty grid, max_steps=4 -> res_timeout=1, res_steps=4, exactly 5 vox_req acks consumed.
- Start voxel solid: start (10,10,10) solid -> res_hit=1, res_steps=0, res_face=7, res_t=0.
- Handshake stress: vox_ack delayed 0-3 random cycles; res_ready held low 5 cycles -> result fields stable while res_valid=1; start_ready low until the cycle after acceptance.
- Abort/reset: assert abort during STEP -> IDLE next cycle, no res_valid; assert rst mid-QUERY -> all outputs at reset values in the same cycle.
